// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling display bus receiver.
package scroll_pkg;

  localparam int WIN_W = 16;
  localparam int NIB_W = 4;
  localparam int VAL_W = 32;
  localparam int CNT_W = 4;

  localparam logic [WIN_W-1:0] IDLE_PAT_DEF = 16'hAAAA;

  // Window index (0-based) of the last window that completes assembly, and
  // of the last window of the optional wrap verification.
  localparam logic [CNT_W-1:0] CNT_LAST_COLLECT = 4'd4;
  localparam logic [CNT_W-1:0] CNT_LAST_VERIFY  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VERIFY  = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } scroll_state_e;

  // Nibble of the rebuilt value that the window with index cnt (5..8) must
  // bring in as its low nibble once the rotation wraps past the value.
  function automatic logic [NIB_W-1:0] rot_nib(input logic [VAL_W-1:0] value,
                                               input logic [CNT_W-1:0] cnt);
    logic [NIB_W-1:0] nib;
    case (cnt)
      4'd5:    nib = value[31:28];
      4'd6:    nib = value[27:24];
      4'd7:    nib = value[23:20];
      4'd8:    nib = value[19:16];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/scroll_link_chk.sv
// Combinational window-to-window continuity check. The previous window is
// supplied as its trailing 12 bits only, which is all a one-nibble rotation
// carries forward into the next window.
module scroll_link_chk
  import scroll_pkg::*;
(
  input  logic [WIN_W-NIB_W-1:0] prev,
  input  logic [WIN_W-1:0]       cur,
  input  logic [WIN_W-1:0]       idle_pat,
  output logic                   is_idle,
  output logic                   link_ok,
  output logic [NIB_W-1:0]       new_nib
);

  assign is_idle = (cur == idle_pat);
  assign link_ok = (cur[WIN_W-1:NIB_W] == prev);
  assign new_nib = cur[NIB_W-1:0];

endmodule

// File: rtl/scroll_rx.sv
// Receive end of the 16-bit scrolling display bus. Rebuilds the 32-bit value
// from five successive windows and publishes it with a one-tick valid pulse.
// Optional feature: define SCROLL_RX_WRAP_CHECK_EN to additionally verify the
// next four windows of the rotation before publishing.
module scroll_rx
  import scroll_pkg::*;
#(
  parameter logic [WIN_W-1:0] IDLE_PAT = IDLE_PAT_DEF,
  parameter int               ERR_W    = 4
) (
  input  logic              clk3hz,
  input  logic              clr,
  input  logic [WIN_W-1:0]  dataBus,
  output logic [VAL_W-1:0]  number_out,
  output logic              valid,
  output logic              busy,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  scroll_state_e            state_q, state_d;
  logic [WIN_W-1:0]         hi_q, hi_d;
  logic [WIN_W-NIB_W-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [VAL_W-1:0]         val_q, val_d;
  logic                     pend_q, pend_d;
  logic [VAL_W-1:0]         number_out_q, number_out_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic [ERR_W-1:0]         err_cnt_q, err_cnt_d;

  logic                     is_idle_s;
  logic                     link_ok_s;
  logic [NIB_W-1:0]         new_nib_s;
  logic                     err_inc_s;

  scroll_link_chk u_link_chk (
    .prev     (prev_q),
    .cur      (dataBus),
    .idle_pat (IDLE_PAT),
    .is_idle  (is_idle_s),
    .link_ok  (link_ok_s),
    .new_nib  (new_nib_s)
  );

  // Next-state, assembly and error-count logic for one bus sample per tick.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    val_d        = val_q;
    pend_d       = pend_q;
    number_out_d = number_out_q;
    valid_d      = 1'b0;
    err_inc_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!is_idle_s) begin
          hi_d    = dataBus;
          prev_d  = dataBus[WIN_W-NIB_W-1:0];
          cnt_d   = 4'd1;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (is_idle_s) begin
          err_inc_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (!link_ok_s) begin
          err_inc_s = 1'b1;
          state_d   = ST_ERR;
        end else begin
          prev_d = dataBus[WIN_W-NIB_W-1:0];
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST_COLLECT) begin
            // The accepted window is {prev, new_nib}, i.e. the low half.
            val_d = {hi_q, prev_q, new_nib_s};
`ifdef SCROLL_RX_WRAP_CHECK_EN
            state_d = ST_VERIFY;
`else
            pend_d  = 1'b1;
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end

`ifdef SCROLL_RX_WRAP_CHECK_EN
      ST_VERIFY: begin
        if (is_idle_s) begin
          err_inc_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (!link_ok_s ||
                     (new_nib_s != rot_nib(val_q, cnt_q)) ||
                     ((cnt_q == CNT_LAST_VERIFY) && (dataBus != val_q[VAL_W-1:WIN_W]))) begin
          err_inc_s = 1'b1;
          state_d   = ST_ERR;
        end else begin
          prev_d = dataBus[WIN_W-NIB_W-1:0];
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST_VERIFY) begin
            pend_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_VERIFY;
          end
        end
      end
`endif

      ST_DONE: begin
        // Publish one tick after the final window; the bus is ignored here
        // apart from the return to idle.
        if (pend_q) begin
          number_out_d = val_q;
          valid_d      = 1'b1;
          pend_d       = 1'b0;
        end else begin
          number_out_d = number_out_q;
        end
        if (is_idle_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_ERR: begin
        if (is_idle_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (err_inc_s && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end

    busy_d = (state_d == ST_COLLECT) || (state_d == ST_VERIFY);
    err_d  = (state_d == ST_ERR);
  end

  // State and output registers; async clear discards any partial reception.
  always_ff @(posedge clk3hz or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      hi_q         <= {WIN_W{1'b0}};
      prev_q       <= {(WIN_W-NIB_W){1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      val_q        <= {VAL_W{1'b0}};
      pend_q       <= 1'b0;
      number_out_q <= {VAL_W{1'b0}};
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= {ERR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      val_q        <= val_d;
      pend_q       <= pend_d;
      number_out_q <= number_out_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign number_out = number_out_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_scroll_rx.sv
// Self-checking bench for scroll_rx: directed cases plus randomized frames,
// checked against a frame-level model of the scrolling protocol.
module tb_scroll_rx;

  localparam logic [15:0] IDLE = 16'hAAAA;
`ifdef SCROLL_RX_WRAP_CHECK_EN
  localparam int NWIN = 9;
`else
  localparam int NWIN = 5;
`endif
  localparam int K_OK    = 0;
  localparam int K_ABORT = 1;
  localparam int K_BREAK = 2;

  logic        clk3hz = 1'b0;
  logic        clr;
  logic [15:0] dataBus;
  logic [31:0] number_out;
  logic        valid;
  logic        busy;
  logic        err;
  logic [3:0]  err_cnt;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_num     = 32'd0;
  int          exp_cnt     = 0;

  scroll_rx dut (
    .clk3hz     (clk3hz),
    .clr        (clr),
    .dataBus    (dataBus),
    .number_out (number_out),
    .valid      (valid),
    .busy       (busy),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk3hz = ~clk3hz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window s of value v: the value rotated left by s nibbles, top half.
  function automatic logic [15:0] win(input logic [31:0] v, input int s);
    logic [63:0] d;
    logic [31:0] r;
    d = {v, v};
    r = d[63 - (s % 8) * 4 -: 32];
    return r[31:16];
  endfunction

  function automatic bit good_val(input logic [31:0] v);
    for (int s = 0; s < 8; s++) if (win(v, s) == IDLE) return 1'b0;
    return 1'b1;
  endfunction

  // One tick: drive the bus, let the edge pass, update the model, compare.
  task automatic step(input logic [15:0] b, input bit pub, input logic [31:0] pv,
                      input bit inc, input bit busy_e, input bit err_e);
    dataBus = b;
    @(posedge clk3hz);
    @(negedge clk3hz);
    if (pub) exp_num = pv;
    if (inc && exp_cnt < 15) exp_cnt++;
    chk("valid", {31'd0, valid}, {31'd0, pub});
    chk("busy", {31'd0, busy}, {31'd0, busy_e});
    chk("err", {31'd0, err}, {31'd0, err_e});
    chk("err_cnt", {28'd0, err_cnt}, 32'(exp_cnt));
    chk("number_out", number_out, exp_num);
  endtask

  task automatic run_frame(input logic [31:0] v, input int kind, input int pos,
                           input logic [15:0] bad, input int trail);
    logic [15:0] g;
    if (kind == K_OK) begin
      for (int s = 0; s <= NWIN + trail; s++)
        step((s == NWIN + trail) ? IDLE : win(v, s), s == NWIN, v, 1'b0, s <= NWIN - 2, 1'b0);
    end else if (kind == K_ABORT) begin
      for (int s = 0; s <= pos; s++)
        step((s < pos) ? win(v, s) : IDLE, 1'b0, 32'd0, s == pos, s < pos, 1'b0);
    end else begin
      for (int s = 0; s <= pos + trail + 1; s++) begin
        do g = 16'($urandom); while (g == IDLE);
        if (s < pos) g = win(v, s);
        else if (s == pos) g = bad;
        else if (s > pos + trail) g = IDLE;
        step(g, 1'b0, 32'd0, s == pos, s < pos, (s >= pos) && (s <= pos + trail));
      end
    end
  endtask

  function automatic logic [15:0] make_bad(input logic [15:0] w);
    logic [15:0] b;
    int          x;
    do begin
      x = $urandom_range(1, 4095);
      b = w ^ {x[11:0], 4'h0};
    end while (b == IDLE);
    return b;
  endfunction

  initial begin
    logic [31:0] v;
    int          kind;
    int          pos;
    clr     = 1'b0;
    dataBus = IDLE;
    @(negedge clk3hz);
    @(negedge clk3hz);
    chk("rst_number_out", number_out, 32'd0);
    chk("rst_flags", {29'd0, valid, busy, err}, 32'd0);
    chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
    clr = 1'b1;

    // Case 1: clean reception after an idle window.
    step(IDLE, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    run_frame(32'h12345678, K_OK, 0, 16'h0000, 0);
    chk("case1_value", number_out, 32'h12345678);

    // Case 2: continuity break, then recovery on idle.
    run_frame(32'h12345678, K_BREAK, 2, 16'h9999, 0);
    // Case 3: abort on idle, then a full clean run.
    run_frame(32'h12345678, K_ABORT, 2, 16'h0000, 0);
    run_frame(32'h87654321, K_OK, 0, 16'h0000, 1);
    chk("case3_value", number_out, 32'h87654321);

`ifdef SCROLL_RX_WRAP_CHECK_EN
    // Case 5: wrap check catches a bad nibble with intact continuity.
    run_frame(32'h12345678, K_OK, 0, 16'h0000, 0);
    run_frame(32'h12345678, K_BREAK, 7, 16'h8120, 1);
`endif

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      do v = $urandom; while (!good_val(v));
      kind = $urandom_range(0, 2);
      pos  = $urandom_range(1, NWIN - 1);
      run_frame(v, kind, pos, make_bad(win(v, pos)), $urandom_range(0, 3));
      for (int i = 0; i < $urandom_range(0, 2); i++)
        step(IDLE, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    end

    // Case 4: async reset in the middle of a reception.
    v = 32'h12345678;
    step(win(v, 0), 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(win(v, 1), 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(win(v, 2), 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    #2 clr = 1'b0;
    #1;
    chk("midrst_number_out", number_out, 32'd0);
    chk("midrst_flags", {29'd0, valid, busy, err}, 32'd0);
    chk("midrst_err_cnt", {28'd0, err_cnt}, 32'd0);
    exp_num = 32'd0;
    exp_cnt = 0;
    dataBus = IDLE;
    @(negedge clk3hz);
    @(negedge clk3hz);
    clr = 1'b1;
    step(IDLE, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    run_frame(v, K_OK, 0, 16'h0000, 2);
    chk("case4_value", number_out, 32'h12345678);

    // Case 6: seventeen breaks saturate the error counter.
    for (int f = 0; f < 17; f++) begin
      pos = $urandom_range(1, NWIN - 1);
      run_frame(v, K_BREAK, pos, make_bad(win(v, pos)), $urandom_range(0, 2));
    end
    chk("case6_sat", {28'd0, err_cnt}, 32'h0000000F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
